prog_serial_sender: RTL and testbench

Serial programming master that drives the chip's SCLK/SDI/CS programming port. It shifts one configuration frame into the on-chip programmer, MSB first.
Used in the FPGA test harness and in loopback verification of the programmer, running from the 24 MHz system clock.
It latches a parallel frame on a start request, generates the serial clock, chip select and data, then signals completion.

---
 rtl/prog_serial_sender.sv | 152 +++++++++++++++
 tb/tb_prog_serial_sender.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_serial_sender.sv
`default_nettype none
// ============================================================================
// Module   : prog_serial_sender
// Brief    : Serial programming master; shifts one frame MSB-first on SCLK/SDI/CS.
// Revision : 1.0 - initial release
// ============================================================================
module prog_serial_sender #(
  parameter int FRAME_W = 100,
  parameter int CLK_DIV = 6
) (
  input  logic               CLK_24M,
  input  logic               reset,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame,
  output logic               busy,
  output logic               done,
  output logic               SCLK,
  output logic               SDI,
  output logic               CS
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [DIV_W-1:0] C_DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] C_BIT_MAX = BIT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_SCK_HI = 3'd2,
    S_SCK_LO = 3'd3,
    S_HOLD   = 3'd4,
    S_GAP    = 3'd5
  } state_t;

  state_t             r_state, w_state;
  logic [DIV_W-1:0]   r_div, w_div;
  logic [BIT_W-1:0]   r_bit, w_bit;
  logic [FRAME_W-1:0] r_shift, w_shift;
  logic               w_busy, w_done, w_sclk, w_sdi, w_cs;
  logic               w_div_end;

  assign w_div_end = (r_div == C_DIV_MAX);

  always_ff @(posedge CLK_24M or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      SCLK    <= 1'b0;
      SDI     <= 1'b0;
      CS      <= 1'b1;
    end else begin
      r_state <= w_state;
      r_div   <= w_div;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      busy    <= w_busy;
      done    <= w_done;
      SCLK    <= w_sclk;
      SDI     <= w_sdi;
      CS      <= w_cs;
    end
  end

  // r_shift holds the bits still to be sent, next one in the MSB position.
  always_comb begin
    w_state = r_state;
    w_div   = r_div;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_busy  = busy;
    w_done  = 1'b0;
    w_sclk  = SCLK;
    w_sdi   = SDI;
    w_cs    = CS;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_shift = frame << 1;
          w_sdi   = frame[FRAME_W-1];
          w_cs    = 1'b0;
          w_busy  = 1'b1;
          w_div   = '0;
          w_bit   = '0;
          w_state = S_SETUP;
        end
      end
      S_SETUP, S_SCK_LO: begin
        if (w_div_end) begin
          w_div   = '0;
          w_sclk  = 1'b1;
          w_state = S_SCK_HI;
        end else begin
          w_div = r_div + 1'b1;
        end
      end
      S_SCK_HI: begin
        if (w_div_end) begin
          w_div  = '0;
          w_sclk = 1'b0;
          if (r_bit == C_BIT_MAX) begin
            w_state = S_HOLD;
          end else begin
            w_sdi   = r_shift[FRAME_W-1];
            w_shift = r_shift << 1;
            w_bit   = r_bit + 1'b1;
            w_state = S_SCK_LO;
          end
        end else begin
          w_div = r_div + 1'b1;
        end
      end
      S_HOLD: begin
        if (w_div_end) begin
          w_div   = '0;
          w_cs    = 1'b1;
          w_sdi   = 1'b0;
          w_state = S_GAP;
        end else begin
          w_div = r_div + 1'b1;
        end
      end
      S_GAP: begin
        if (w_div_end) begin
          w_div   = '0;
          w_bit   = '0;
          w_done  = 1'b1;
          w_busy  = 1'b0;
          w_state = S_IDLE;
        end else begin
          w_div = r_div + 1'b1;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_div   = '0;
        w_bit   = '0;
        w_busy  = 1'b0;
        w_sclk  = 1'b0;
        w_sdi   = 1'b0;
        w_cs    = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_prog_serial_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_serial_sender
// Brief    : Self-checking bench: frame table, scoreboard monitor, corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_prog_serial_sender;

  localparam int FW = 100;
  localparam int CD = 6;
  // Receiver field layout assumed for the loopback decode
  localparam int LB_HSNR = 99;
  localparam int LB_HDR  = 98;
  localparam int LB_DLL  = 97;
  localparam int LB_GTHDR_LO = 93;
  localparam int LB_ATHHI_LO = 84;

  logic          clk = 1'b0;
  logic          reset, start, start1;
  logic [FW-1:0] frame;
  logic [0:0]    frame1;
  logic          busy, done, sclk, sdi, cs;
  logic          busy1, done1, sclk1, sdi1, cs1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #21 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  prog_serial_sender #(.FRAME_W(FW), .CLK_DIV(CD)) dut (
    .CLK_24M(clk), .reset(reset), .start(start), .frame(frame),
    .busy(busy), .done(done), .SCLK(sclk), .SDI(sdi), .CS(cs)
  );

  prog_serial_sender #(.FRAME_W(1), .CLK_DIV(1)) dut1 (
    .CLK_24M(clk), .reset(reset), .start(start1), .frame(frame1),
    .busy(busy1), .done(done1), .SCLK(sclk1), .SDI(sdi1), .CS(cs1)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [FW-1:0] frame;
    int            e0;
  } sb_t;
  sb_t sb_q[$];
  sb_t mon_e;

  // Bus monitor: samples on the falling clock edge, rebuilds frames from SCLK rises
  logic          p_sclk = 1'b0, p_cs = 1'b1, p_sdi = 1'b0;
  logic [FW-1:0] cap = '0;
  logic [FW-1:0] last_rx = '0;
  int n_rise = 0, cs_fall_cyc = 0, cs_rise_cyc = 0, cur_e0 = 0;
  int sdi_chg_cyc = 0, last_rise_cyc = 0, done_cnt = 0, fall_cnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
    end else begin
      if (sdi !== p_sdi) begin
        chk("sdi_changes_with_sclk_low", sclk, 1'b0);
        chk("sdi_hold_after_rise", ((cyc - last_rise_cyc) >= CD), 1'b1);
        sdi_chg_cyc = cyc;
      end
      if (!cs && p_cs) begin
        fall_cnt++;
        cs_fall_cyc = cyc;
        n_rise = 0;
        cap = '0;
        chk("busy_at_accept", busy, 1'b1);
        chk("frame_was_requested", (sb_q.size() != 0), 1'b1);
        if (sb_q.size() != 0) begin
          cur_e0 = sb_q[0].e0;
          chk("cs_fall_edge", cyc, cur_e0);
        end
      end
      if (sclk && !p_sclk) begin
        n_rise++;
        last_rise_cyc = cyc;
        cap = {cap[FW-2:0], sdi};
        chk("cs_low_at_sclk_rise", cs, 1'b0);
        chk("sdi_setup_before_rise", ((cyc - sdi_chg_cyc) >= CD), 1'b1);
      end
      if (cs && !p_cs) begin
        cs_rise_cyc = cyc;
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          chk("frame_bits", cap, mon_e.frame);
          chk("sclk_rise_count", n_rise, FW);
          chk("cs_low_cycles", cyc - cs_fall_cyc, (2*FW+1)*CD);
          last_rx = cap;
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_latency", cyc - cur_e0, (2*FW+2)*CD);
        chk("gap_cs_high_cycles", cyc - cs_rise_cyc, CD);
        chk("busy_low_at_done", busy, 1'b0);
      end
    end
    p_sclk = sclk;
    p_cs   = cs;
    p_sdi  = sdi;
  end

  task automatic send(input logic [FW-1:0] f, output int e0);
    @(negedge clk);
    frame = f;
    start = 1'b1;
    e0 = cyc + 1;
    sb_q.push_back('{f, e0});
    @(negedge clk);
    start = 1'b0;
    frame = ~f;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done_in_budget", done, 1'b1);
  endtask

  typedef struct {
    logic [FW-1:0] frame;
    int            done_lat;
    int            rises;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int e0;
    int f0;
    int d0;
    int lowc, rises1, dcyc;
    logic ps, rsdi, seen_high;
    logic [FW-1:0] lb;

    reset = 1'b1; start = 1'b0; start1 = 1'b0; frame = '0; frame1 = '0;
    repeat (3) @(negedge clk);
    chk("reset_cs", cs, 1'b1);
    chk("reset_sclk", sclk, 1'b0);
    chk("reset_sdi", sdi, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_cs_w1", cs1, 1'b1);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    lb = '0;
    lb[LB_HSNR] = 1'b1;
    lb[LB_HDR]  = 1'b1;
    lb[LB_DLL]  = 1'b1;
    lb[LB_GTHDR_LO +: 4] = 4'h9;
    lb[LB_ATHHI_LO +: 9] = 9'h155;
    lb[7:0] = 8'h3C;

    vecs[0] = '{100'h5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5, (2*FW+2)*CD, FW};
    vecs[1] = '{{FW{1'b0}}, 1212, 100};
    vecs[2] = '{{FW{1'b1}}, 1212, 100};
    vecs[3] = '{{1'b1, {(FW-1){1'b0}}}, 1212, 100};
    vecs[4] = '{{{(FW-1){1'b0}}, 1'b1}, 1212, 100};
    vecs[5] = '{lb, 1212, 100};

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].frame, e0);
      wait_done(1500);
      chk("vec_done_latency", cyc - e0, vecs[i].done_lat);
      chk("vec_rises", n_rise, vecs[i].rises);
      chk("vec_rx_word", last_rx, vecs[i].frame);
      repeat (5) @(negedge clk);
    end
    chk("lb_hsnr_en", last_rx[LB_HSNR], 1'b1);
    chk("lb_hdr_en", last_rx[LB_HDR], 1'b1);
    chk("lb_dll_en", last_rx[LB_DLL], 1'b1);
    chk("lb_gthdr", last_rx[LB_GTHDR_LO +: 4], 4'h9);
    chk("lb_athhi", last_rx[LB_ATHHI_LO +: 9], 9'h155);

    // start pulses while busy must be ignored
    f0 = fall_cnt;
    send(100'h1_2345_6789_ABCD_EF01_2345_6789, e0);
    while (cyc < e0 + 9) @(negedge clk);
    start = 1'b1; frame = 100'hF_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F;
    @(negedge clk);
    start = 1'b0;
    while (cyc < e0 + 499) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1500);
    seen_high = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      seen_high = seen_high | sclk | !cs;
    end
    chk("idle_after_done", seen_high, 1'b0);
    chk("single_frame_sent", fall_cnt - f0, 1);
    chk("scoreboard_empty", sb_q.size(), 0);

    // start held high: second frame accepted at the edge after done
    f0 = fall_cnt;
    @(negedge clk);
    frame = 100'hC_3C3C_3C3C_3C3C_3C3C_3C3C_3C3C;
    start = 1'b1;
    sb_q.push_back('{frame, cyc + 1});
    @(negedge clk);
    wait_done(1500);
    frame = 100'h0_F00D_BEEF_CAFE_1234_5678_9ABC;
    sb_q.push_back('{frame, cyc + 1});
    @(negedge clk);
    frame = '0;
    wait_done(1500);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("held_start_two_frames", fall_cnt - f0, 2);
    chk("held_rx_second", last_rx, 100'h0_F00D_BEEF_CAFE_1234_5678_9ABC);

    // asynchronous reset mid-frame
    d0 = done_cnt;
    send(100'h9_8765_4321_0FED_CBA9_8765_4321, e0);
    while (cyc < e0 + 300) @(negedge clk);
    #3 reset = 1'b1;
    #1;
    chk("midreset_cs", cs, 1'b1);
    chk("midreset_sclk", sclk, 1'b0);
    chk("midreset_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (1300) @(negedge clk);
    chk("no_done_after_abort", done_cnt - d0, 0);
    send(100'h6_DB6D_B6DB_6DB6_DB6D_B6DB_6DB6, e0);
    wait_done(1500);
    chk("post_reset_frame", last_rx, 100'h6_DB6D_B6DB_6DB6_DB6D_B6DB_6DB6);
    chk("post_reset_done_latency", cyc - e0, 1212);

    // FRAME_W=1, CLK_DIV=1
    @(negedge clk);
    frame1 = 1'b1;
    start1 = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    start1 = 1'b0;
    frame1 = 1'b0;
    lowc = 0; rises1 = 0; dcyc = -1; ps = 1'b0; rsdi = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!cs1) lowc++;
      if (sclk1 && !ps) begin
        rises1++;
        rsdi = sdi1;
      end
      ps = sclk1;
      if (done1) dcyc = cyc;
      @(negedge clk);
    end
    chk("w1_cs_low_cycles", lowc, 3);
    chk("w1_sclk_rises", rises1, 1);
    chk("w1_sdi_at_rise", rsdi, 1'b1);
    chk("w1_done_latency", dcyc - e0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
